// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   MD_OP_W     : width of the E-stage md_op code
//   md_op_e     : MD_* operation codes driven by the decoder
//   md_state_e  : sequencer states
package md_unit_ctrl_pkg;

  localparam int unsigned MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

endpackage

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, models the
// multi-cycle latency with a busy counter and raises the D-stage stall.
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   md_op          : E-stage MD_* operation code
//   start          : E-stage instruction is mult/multu/div/divu
//   A, B           : forwarded rs / rt operands
//   exc_req        : CP0 exception/interrupt, cancels new E-stage effects
//   md_use_D       : D-stage instruction is an MD op
//   busy           : operation in flight
//   stall_md       : stall request to the hazard unit
//   md_rd          : HI for mfhi, LO for mflo, else 0
//   HI, LO         : architectural HI/LO registers
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               start,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  input  logic               exc_req,
  input  logic               md_use_D,
  output logic               busy,
  output logic               stall_md,
  output logic [31:0]        md_rd,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi, r_lo;
  logic [31:0]        r_pend_hi, r_pend_lo;
  logic               r_pend_wr;

  md_op_e             w_op;
  logic               w_is_arith;
  logic               w_launch;
  logic               w_done;
  logic               w_wr_hi, w_wr_lo;
  logic [31:0]        w_pend_hi, w_pend_lo;
  logic               w_pend_wr;
  logic [CNT_W-1:0]   w_cnt_load;

  // Arithmetic datapath
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_a_mag, w_b_mag, w_b_mag_safe, w_b_safe;
  logic [31:0]        w_sq_mag, w_sr_mag, w_sq, w_sr;

  assign w_op = md_op_e'(md_op);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 r 0
  // because the magnitude of 0x80000000 is representable unsigned.
  assign w_a_mag      = A[31] ? (~A + 32'd1) : A;
  assign w_b_mag      = B[31] ? (~B + 32'd1) : B;
  assign w_b_mag_safe = (w_b_mag == '0) ? 32'd1 : w_b_mag;
  assign w_b_safe     = (B == '0) ? 32'd1 : B;
  assign w_sq_mag     = w_a_mag / w_b_mag_safe;
  assign w_sr_mag     = w_a_mag % w_b_mag_safe;
  assign w_sq         = (A[31] ^ B[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr         = A[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

  always_comb begin
    w_is_arith = 1'b0;
    w_pend_hi  = '0;
    w_pend_lo  = '0;
    w_pend_wr  = 1'b0;
    w_cnt_load = '0;
    case (w_op)
      MD_MULT: begin
        w_is_arith = 1'b1;
        w_pend_hi  = w_prod_s[63:32];
        w_pend_lo  = w_prod_s[31:0];
        w_pend_wr  = 1'b1;
        w_cnt_load = CNT_W'(MULT_CYCLES);
      end
      MD_MULTU: begin
        w_is_arith = 1'b1;
        w_pend_hi  = w_prod_u[63:32];
        w_pend_lo  = w_prod_u[31:0];
        w_pend_wr  = 1'b1;
        w_cnt_load = CNT_W'(MULT_CYCLES);
      end
      MD_DIV: begin
        w_is_arith = 1'b1;
        w_pend_hi  = w_sr;
        w_pend_lo  = w_sq;
        w_pend_wr  = (B != '0);
        w_cnt_load = CNT_W'(DIV_CYCLES);
      end
      MD_DIVU: begin
        w_is_arith = 1'b1;
        w_pend_hi  = A % w_b_safe;
        w_pend_lo  = A / w_b_safe;
        w_pend_wr  = (B != '0);
        w_cnt_load = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  assign w_launch = start & ~exc_req & ~busy & w_is_arith;
  assign w_done   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
  assign w_wr_hi  = (w_op == MD_MTHI) & ~busy & ~exc_req;
  assign w_wr_lo  = (w_op == MD_MTLO) & ~busy & ~exc_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (r_state == ST_BUSY);
    stall_md = md_use_D & (busy | (start & ~exc_req));
    case (w_op)
      MD_MFHI: md_rd = r_hi;
      MD_MFLO: md_rd = r_lo;
      default: md_rd = '0;
    endcase
  end

  // Counter, pending result and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_launch) begin
        r_cnt     <= w_cnt_load;
        r_pend_hi <= w_pend_hi;
        r_pend_lo <= w_pend_lo;
        r_pend_wr <= w_pend_wr;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  localparam int unsigned MULT_C = 5;
  localparam int unsigned DIV_C  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A_i, B_i;
  logic        exc_req;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] md_rd, HI, LO;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_op    (md_op),
    .start    (start),
    .A        (A_i),
    .B        (B_i),
    .exc_req  (exc_req),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .md_rd    (md_rd),
    .HI       (HI),
    .LO       (LO)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics using 64-bit integer arithmetic.
  task automatic ref_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 4'(MD_MULT)) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == 4'(MD_MULTU)) begin
      pu = ua * ub;
      hi = pu[63:32];
      lo = pu[31:0];
    end else if (op == 4'(MD_DIV) && b != 0) begin
      p  = sa / sb;
      lo = p[31:0];
      p  = sa % sb;
      hi = p[31:0];
    end else if (op == 4'(MD_DIVU) && b != 0) begin
      pu = ua / ub;
      lo = pu[31:0];
      pu = ua % ub;
      hi = pu[31:0];
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic do_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic exc, input logic used);
    int unsigned n;
    logic [31:0] old_hi, old_lo;
    n = (op == 4'(MD_MULT) || op == 4'(MD_MULTU)) ? MULT_C : DIV_C;
    old_hi = exp_hi;
    old_lo = exp_lo;
    md_op = op; start = 1'b1; A_i = a; B_i = b; exc_req = exc; md_use_D = used;
    #1;
    chk("stall_start", {31'd0, stall_md}, {31'd0, used & ~exc});
    if (!exc) ref_arith(op, a, b, exp_hi, exp_lo);
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'(MD_NONE); exc_req = 1'b0; A_i = $urandom; B_i = $urandom;
    if (exc) begin
      chk("exc_busy", {31'd0, busy}, 32'd0);
    end else begin
      for (int unsigned c = 1; c <= n; c++) begin
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("stall_run", {31'd0, stall_md}, {31'd0, used});
        chk("hi_hold", HI, old_hi);
        chk("lo_hold", LO, old_lo);
        @(posedge clk); #1;
      end
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("stall_done", {31'd0, stall_md}, 32'd0);
    end
    chk("hi_result", HI, exp_hi);
    chk("lo_result", LO, exp_lo);
    md_use_D = 1'b0;
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] a, input logic exc);
    md_op = to_hi ? 4'(MD_MTHI) : 4'(MD_MTLO); A_i = a; exc_req = exc;
    @(posedge clk); #1;
    md_op = 4'(MD_NONE); exc_req = 1'b0; A_i = $urandom;
    if (!exc) begin
      if (to_hi) exp_hi = a;
      else       exp_lo = a;
    end
    chk("mt_hi", HI, exp_hi);
    chk("mt_lo", LO, exp_lo);
  endtask

  task automatic do_mf(input logic from_hi);
    md_op = from_hi ? 4'(MD_MFHI) : 4'(MD_MFLO);
    #1;
    chk(from_hi ? "mfhi_rd" : "mflo_rd", md_rd, from_hi ? exp_hi : exp_lo);
    md_op = 4'(MD_NONE);
    #1;
    chk("none_rd", md_rd, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; md_op = '0; start = 1'b0; A_i = '0; B_i = '0;
    exc_req = 1'b0; md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    do_arith(4'(MD_MULT), 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFF1);
    do_arith(4'(MD_DIVU), 32'd7, 32'd2, 1'b0, 1'b0);
    do_arith(4'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    do_arith(4'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo_const", LO, 32'h8000_0000);
    chk("ovf_hi_const", HI, 32'h0);
    do_mt(1'b1, 32'h11, 1'b0);
    do_mt(1'b0, 32'h22, 1'b0);
    do_arith(4'(MD_DIV), 32'd1234, 32'd0, 1'b0, 1'b0);
    chk("dz_hi_const", HI, 32'h11);
    chk("dz_lo_const", LO, 32'h22);
    do_arith(4'(MD_MULT), 32'd9, 32'd9, 1'b1, 1'b1);
    do_mt(1'b1, 32'hDEAD_BEEF, 1'b1);
    do_arith(4'(MD_MULTU), 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b1);
    do_mf(1'b0);
    do_mf(1'b1);

    // mthi during busy must be ignored
    md_op = 4'(MD_MULT); start = 1'b1; A_i = 32'd3; B_i = 32'd4;
    ref_arith(4'(MD_MULT), 32'd3, 32'd4, exp_hi, exp_lo);
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'(MD_MTHI); A_i = 32'h5555_5555;
    @(posedge clk); #1;
    md_op = 4'(MD_NONE);
    repeat (MULT_C - 1) @(posedge clk);
    #1;
    chk("busy_mt_busy", {31'd0, busy}, 32'd0);
    chk("busy_mt_hi", HI, exp_hi);
    chk("busy_mt_lo", LO, exp_lo);

    // Async reset in the middle of a divide
    do_mt(1'b1, 32'hA5A5_0001, 1'b0);
    md_op = 4'(MD_DIV); start = 1'b1; A_i = 32'd100; B_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'(MD_NONE);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_arith(4'(MD_MULT), 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0);

    // Randomized mix against the reference
    for (int unsigned it = 0; it < 30; it++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if (op <= 4'(MD_DIVU))
        do_arith(op, a, b, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      else if (op == 4'(MD_MTHI) || op == 4'(MD_MTLO))
        do_mt(op == 4'(MD_MTHI), a, $urandom_range(0, 5) == 0);
      else
        do_mf(op == 4'(MD_MFHI));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
